// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Optional readback CRC is enabled with CCFF_READBACK_EN.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WORD_W_DEF = 8;
    localparam int LEN_W_DEF  = 16;

    localparam logic [7:0] CRC_POLY = 8'h07;

endpackage

// File: rtl/ccff_crc8.sv
// Serial MSB-first CRC-8 accumulator with synchronous clear and enable.
// Used by ccff_loader only when CCFF_READBACK_EN is defined.
module ccff_crc8
    import ccff_loader_pkg::*;
(
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic fb;

    assign fb = crc[7] ^ din;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Loads a bitstream into a configuration flip-flop chain, LSB first.
// Define CCFF_READBACK_EN to add the tail readback CRC check.
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [LEN_W-1:0]  chain_len,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
`ifdef CCFF_READBACK_EN
    input  logic [7:0]        crc_expected,
    output logic [7:0]        rb_crc,
    output logic              rb_mismatch,
`endif
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    state_t            state, state_n;
    logic [LEN_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [WORD_W-1:0] word, word_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        word_n  = word;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cnt_n   = chain_len;
                    state_n = (chain_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (s_valid && s_ready) begin
                    word_n  = s_data;
                    idx_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                cnt_n = cnt - LEN_W'(1);
                idx_n = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                if (cnt == LEN_W'(1)) begin
                    state_n = DONE;
                end else if (idx == IDX_LAST) begin
                    state_n = FETCH;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with state.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            word          <= '0;
            s_ready       <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            word          <= word_n;
            s_ready       <= (state_n == FETCH);
            ccff_shift_en <= (state_n == SHIFT);
            ccff_head     <= (state_n == SHIFT) && word_n[idx_n];
            busy          <= (state_n != IDLE);
            done          <= (state_n == DONE);
        end
    end

`ifdef CCFF_READBACK_EN
    logic start_acc;

    assign start_acc = (state == IDLE) && start;

    ccff_crc8 u_crc (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clr      (start_acc),
        .en       (ccff_shift_en),
        .din      (ccff_tail),
        .crc      (rb_crc)
    );

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            rb_mismatch <= 1'b0;
        end else if (start_acc) begin
            rb_mismatch <= 1'b0;
        end else if (state == DONE) begin
            rb_mismatch <= (rb_crc != crc_expected);
        end
    end
`else
    logic unused_tail;

    assign unused_tail = ccff_tail;
`endif

endmodule
